// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the RISC Mini execute stage.
// Single-cycle ops register their result on the accept edge. MUL and
// DIVU/REMU iterate one bit per cycle through a shared hi/lo register pair.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Input side: in_valid/in_ready, where op, a and b are sampled on
// that edge and the producer holds them stable until then. Output side:
// out_valid/out_ready, where result and cc stay stable while out_valid is
// high until out_ready is seen.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       cc,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;
    localparam logic [3:0] OP_BLE  = 4'd10;
    localparam logic [3:0] OP_BGT  = 4'd11;
    localparam logic [3:0] OP_BGE  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REMU = 4'd14;

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    logic [3:0]       op_q;
    // MUL: opd = multiplicand, hi = partial product high, lo = multiplier/product low.
    // DIV: opd = divisor, hi = partial remainder, lo = dividend shifting into quotient.
    logic [WIDTH-1:0] opd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             accept;
    logic             is_div;
    logic             multi;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ov;
    logic             sub_ov;
    logic             borrow;
    logic             lt_s;
    logic             z_f;
    logic [WIDTH-1:0] sc_result;
    logic [3:0]       sc_cc;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    // Divide by zero short-circuits to the single-cycle path.
    assign is_div = (op == OP_DIVU) || (op == OP_REMU);
    assign multi  = (op == OP_MUL) || (is_div && (b != '0));

    assign sum    = a + b;
    assign diff   = a - b;
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = ((a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]));
    assign borrow = (a < b);
    assign lt_s   = diff[WIDTH-1] ^ sub_ov;
    assign z_f    = (diff == '0);

    // Result and condition codes for every op that completes on the accept edge.
    always_comb begin
        sc_result = '0;
        sc_cc     = 4'b0000;
        case (op)
            OP_ADD:  begin sc_result = sum;  sc_cc = {2'b00, add_ov, 1'b0}; end
            OP_SUB:  begin sc_result = diff; sc_cc = {1'b0, borrow, sub_ov, 1'b0}; end
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_NOT:  sc_result = ~a;
            OP_BEQ:  sc_cc = {3'b000, z_f};
            OP_BNE:  sc_cc = {3'b000, ~z_f};
            OP_BLT:  sc_cc = {3'b000, lt_s};
            OP_BLE:  sc_cc = {3'b000, lt_s | z_f};
            OP_BGT:  sc_cc = {3'b000, ~(lt_s | z_f)};
            OP_BGE:  sc_cc = {3'b000, ~lt_s};
            OP_DIVU: begin sc_result = '1; sc_cc = 4'b1000; end
            OP_REMU: begin sc_result = a;  sc_cc = 4'b1000; end
            default: begin sc_result = '0; sc_cc = 4'b0000; end
        endcase
    end

    // One shift-add multiply step or one restoring-division step.
    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opd : {WIDTH{1'b0}})};
        div_shift = {hi, lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, opd};
        div_ge    = ~div_trial[WIDTH];
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {lo[WIDTH-2:0], div_ge};
        end
    end

    // Control FSM plus datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            counter <= '0;
            op_q    <= 4'd0;
            opd     <= '0;
            hi      <= '0;
            lo      <= '0;
            result  <= '0;
            cc      <= 4'b0000;
        end else begin
            case (state)
                CALC: begin
                    hi      <= step_hi;
                    lo      <= step_lo;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        state <= DONE;
                        if (op_q == OP_MUL) begin
                            result <= step_lo;
                            cc     <= {2'b00, |step_hi, 1'b0};
                        end else begin
                            result <= (op_q == OP_REMU) ? step_hi : step_lo;
                            cc     <= 4'b0000;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (accept) begin
                        op_q <= op;
                        if (multi) begin
                            state   <= CALC;
                            counter <= CNT_W'(WIDTH);
                            hi      <= '0;
                            if (op == OP_MUL) begin
                                opd <= a;
                                lo  <= b;
                            end else begin
                                opd <= b;
                                lo  <= a;
                            end
                        end else begin
                            state  <= DONE;
                            result <= sc_result;
                            cc     <= sc_cc;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed checks of alu_mc at WIDTH=32.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   cc;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    logic [3:0]   br_op  [0:6] = '{4'd9, 4'd12, 4'd11, 4'd10, 4'd7, 4'd8, 4'd9};
    logic [W-1:0] br_a   [0:6] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE,
                                   32'd5, 32'd5, 32'h80000000};
    logic [W-1:0] br_b   [0:6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd1};
    logic         br_exp [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic [3:0]   lg_op  [0:4] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd15};
    logic [W-1:0] lg_exp [0:4] = '{32'h00F01200, 32'hFFF0FF34, 32'hFF00ED34, 32'h0F0FEDCB, 32'h0};

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cc        (cc),
        .busy      (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // Driver tasks: inputs change on the falling edge.
    task automatic drive_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat);
        drive_op(o, x, y);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL reset_flags: got %b expected 001", {out_valid, busy, in_ready});
        else n_pass++;
        n_checks++;
        if ({cc, result} !== 36'h0) $display("FAIL reset_data: got cc=%h result=%h expected 0/0", cc, result);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive_op(4'd0, 32'h7FFFFFFF, 32'h1);
        exp_q.push_back(32'h80000000);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready0: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        drive_op(4'd1, 32'h0, 32'h1);
        exp_q.push_back(32'hFFFFFFFF);
        n_checks++;
        if ({out_valid, in_ready, cc, result} !== {1'b1, 1'b1, 4'b0010, exp_q.pop_front()})
            $display("FAIL b2b_add: got v=%b r=%b cc=%b res=%h expected 1 1 0010 80000000", out_valid, in_ready, cc, result);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, cc, result} !== {1'b1, 1'b1, 4'b0100, exp_q.pop_front()})
            $display("FAIL b2b_sub: got v=%b r=%b cc=%b res=%h expected 1 1 0100 ffffffff", out_valid, in_ready, cc, result);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        run_op(4'd2, 32'h00010000, 32'h00010000, lat);
        n_checks++;
        if (lat !== 33) $display("FAIL mul_latency: got %0d expected 33", lat);
        else n_pass++;
        n_checks++;
        if ({busy, cc, result} !== {1'b0, 4'b0010, 32'h0}) $display("FAIL mul_ovf: got busy=%b cc=%b res=%h expected 0 0010 0", busy, cc, result);
        else n_pass++;
        take();
        run_op(4'd2, 32'd1234, 32'd5678, lat);
        n_checks++;
        if ({cc, result} !== {4'b0000, 32'd7006652} || lat !== 33)
            $display("FAIL mul_small: got cc=%b res=%0d lat=%0d expected 0000 7006652 33", cc, result, lat);
        else n_pass++;
        take();
    endtask

    task automatic test_div();
        int lat;
        run_op(4'd13, 32'd100, 32'd7, lat);
        n_checks++;
        if ({cc, result} !== {4'b0000, 32'd14} || lat !== 33)
            $display("FAIL divu: got cc=%b res=%0d lat=%0d expected 0000 14 33", cc, result, lat);
        else n_pass++;
        take();
        run_op(4'd14, 32'd100, 32'd7, lat);
        n_checks++;
        if ({cc, result} !== {4'b0000, 32'd2} || lat !== 33)
            $display("FAIL remu: got cc=%b res=%0d lat=%0d expected 0000 2 33", cc, result, lat);
        else n_pass++;
        take();
        run_op(4'd13, 32'd5, 32'd0, lat);
        n_checks++;
        if ({cc, result} !== {4'b1000, 32'hFFFFFFFF} || lat !== 1)
            $display("FAIL divu_zero: got cc=%b res=%h lat=%0d expected 1000 ffffffff 1", cc, result, lat);
        else n_pass++;
        take();
        run_op(4'd14, 32'd5, 32'd0, lat);
        n_checks++;
        if ({cc, result} !== {4'b1000, 32'd5} || lat !== 1)
            $display("FAIL remu_zero: got cc=%b res=%h lat=%0d expected 1000 5 1", cc, result, lat);
        else n_pass++;
        take();
    endtask

    task automatic test_branch();
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(br_op[i], br_a[i], br_b[i], lat);
            n_checks++;
            if ({cc, result} !== {3'b000, br_exp[i], 32'h0} || lat !== 1)
                $display("FAIL branch_%0d: got cc=%b res=%h lat=%0d expected cc=000%b res=0 lat=1", i, cc, result, lat, br_exp[i]);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_logic();
        int lat;
        // Leave overflow set first so stale cc bits would show up.
        run_op(4'd0, 32'h7FFFFFFF, 32'h1, lat);
        take();
        for (int i = 0; i < 5; i++) begin
            run_op(lg_op[i], 32'hF0F01234, 32'h0FF0FF00, lat);
            n_checks++;
            if ({cc, result} !== {4'b0000, lg_exp[i]})
                $display("FAIL logic_%0d: got cc=%b res=%h expected 0000 %h", i, cc, result, lg_exp[i]);
            else n_pass++;
            take();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_op(4'd2, 32'd3, 32'd4, lat);
        drive_op(4'd0, 32'd2, 32'd3);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (result !== 32'd12 || cc !== 4'b0000 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        else n_pass++;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready: got %b expected 1", in_ready);
        else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, cc, result} !== {1'b1, 4'b0000, 32'd5})
            $display("FAIL bp_add: got v=%b cc=%b res=%0d expected 1 0000 5", out_valid, cc, result);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", out_valid);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int bad;
        drive_op(4'd2, 32'h0000FFFF, 32'h0000FFFF);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL ar_busy: got %b expected 1", busy);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, cc, result} !== {1'b0, 1'b0, 4'b0000, 32'h0})
            $display("FAIL ar_clear: got v=%b busy=%b cc=%b res=%h expected 0 0 0000 0", out_valid, busy, cc, result);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL ar_release: got %0d bad cycles expected 0", bad);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_div();
        test_branch();
        test_logic();
        test_backpressure();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised-width, multi-cycle ALU for the RISC Mini execute stage; successor to the combinational ALU.
- Adds a valid/ready handshake on input and output, registered results, and iterative unsigned multiply.
- Adds unsigned divide/remainder and divide-by-zero flagging.
- Single-cycle ops sustain one result per cycle. MUL/DIV stall the stage via in_ready.

Parameters:
- WIDTH, 32, datapath width in bits (legal 8..64).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts operation this cycle.
- op  in  4  operation select (encoding below).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/cc valid.
- out_ready  in  1  consumer takes result this cycle.
- result  out  WIDTH  registered result.
- cc  out  4  [3]=div-by-zero, [2]=borrow (underflow), [1]=overflow, [0]=branch true.
- busy  out  1  high in CALC.

Behaviour:
- op encoding:
  - 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOT(~a).
  - 7 BEQ, 8 BNE, 9 BLT, 10 BLE, 11 BGT, 12 BGE.
  - 13 DIVU, 14 REMU.
  - 15 reserved: result=0, cc=0.
- Accept: an op is accepted when in_valid && in_ready. Operands and op are captured on the accept edge. Inputs are ignored otherwise.
- FSM states IDLE, CALC, DONE. Reset state IDLE.
- Reset values: result=0, cc=0, out_valid=0, busy=0, counter=0, internal operand registers=0. in_ready=1 while in IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- IDLE, accept of a single-cycle op (0,1,3-12,15), or DIVU/REMU with b==0: go to DONE. Result and cc are registered on the accept edge, so latency is 1 cycle.
- IDLE, accept of MUL, or DIVU/REMU with b!=0: go to CALC, counter=WIDTH.
- CALC:
  - One iteration per cycle; counter decrements.
  - On the cycle counter reaches 1, load result/cc and go to DONE.
  - Total latency is WIDTH+1 cycles from accept to out_valid.
- DONE:
  - out_valid=1; result and cc stay stable until out_ready.
  - out_ready=1 with no new accept: go to IDLE, out_valid drops next cycle.
  - out_ready=1 with a simultaneous accept: the new op is handled exactly as from IDLE (back-to-back, no bubble).
- Arithmetic, all mod 2^WIDTH:
  - ADD: result=a+b. cc[1]=signed overflow (operand signs equal, result sign differs).
  - SUB: result=a-b. cc[1]=signed overflow ((a^b)&(a^res) MSB). cc[2]=borrow (unsigned a<b).
  - MUL: unsigned shift-add over 2*WIDTH product. result=low WIDTH bits. cc[1]=1 iff high WIDTH bits nonzero.
  - DIVU/REMU: restoring division over WIDTH iterations. result=quotient or remainder respectively.
  - DIVU/REMU with b==0: quotient=all ones, remainder=a, cc[3]=1, 1-cycle path.
  - Logic ops: cc=0.
  - Branch ops: result=0. cc[0] is computed from signed a-b, with N=res MSB, V=sub overflow, Z=res==0:
    - BEQ Z; BNE ~Z; BLT N^V; BLE (N^V)|Z; BGT ~((N^V)|Z); BGE ~(N^V).
    - cc[3:1]=0 for branch ops.
- Unused cc bits are always 0; there are no stale bits from the previous op.
- Reset asserted mid-CALC or mid-DONE aborts the op immediately and asynchronously; all outputs take reset values. No result is emitted after release.
- in_valid held while in_ready=0: the op is not consumed. The producer must hold a/b/op stable until accepted.

Test Plan:
- Back-to-back single-cycle ops: WIDTH=32, ADD 0x7FFFFFFF+1 then SUB 0x0-0x1, out_ready=1 → cycle1 result 0x80000000 cc=0b0010; cycle2 result 0xFFFFFFFF cc=0b0100; in_ready stays 1.
- MUL latency and overflow: MUL 0x00010000*0x00010000 → busy for 32 cycles, out_valid at cycle 33, result 0, cc[1]=1. MUL 1234*5678 → 7006652, cc=0.
- Division: DIVU 100/7 → 14; REMU 100/7 → 2. DIVU 5/0 → 1 cycle, result 0xFFFFFFFF, cc=0b1000. REMU 5/0 → result 5, cc=0b1000.
- Branches with a=0xFFFFFFFE (-2), b=1:
  - BLT → cc[0]=1; BGE → 0; BGT → 0; BLE → 1.
  - a=b=5: BEQ → 1, BNE → 0.
  - a=0x80000000, b=1: BLT → 1 (overflow case).
- Backpressure: MUL result with out_ready=0 for 10 cycles → result/cc held stable, in_ready=0, a new in_valid is not accepted. Raise out_ready with in_valid: ADD 2+3 → next cycle result 5.
- Async reset: assert rst_n=0 at CALC counter=15 → out_valid/busy/result/cc go 0 without a clock edge. After release, in_ready=1 and no spurious out_valid.
